xmit: RTL and testbench

XMIT -- requirements
Module: xmit

---
 rtl/xmit.sv | 121 ++++++++++++
 tb/tb_xmit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/xmit.sv
// Serial frame transmitter: one queued byte plus a frame in flight. Each frame is
// HEADER then payload, both MSB first, followed by GAP forced idle cycles.
module xmit #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned GAP    = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data_in,
    output logic       full,
    output logic       busy,
    output logic       drop,
    output logic       data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_BODY,
        S_GAP
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    state_t      r_state;
    logic [7:0]  r_hold;
    logic        r_full;
    logic [15:0] r_shift;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_gap_cnt;
    logic        r_busy;
    logic        r_drop;
    logic        r_data_out;

    logic w_frame_end;
    logic w_gap_end;
    logic w_engine_free;

    assign w_frame_end = (r_state == S_BODY) && (r_bit_cnt == 3'd7);
    assign w_gap_end   = (r_state == S_GAP) && (r_gap_cnt == GAP_LAST);
    // The engine can take a new byte in IDLE, or on the very edge that ends the
    // last busy cycle, so back-to-back frames and gaps carry no extra idle bit.
    assign w_engine_free = (r_state == S_IDLE)
                         || (w_frame_end && (GAP == 0))
                         || w_gap_end;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
            r_data_out <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_gap_cnt  <= 4'd0;
        end else begin
            r_drop <= load && r_full;

            if (load && !r_full) begin
                r_hold <= data_in;
                r_full <= 1'b1;
            end else if (w_engine_free && r_full) begin
                r_full <= 1'b0;
            end

            if (w_engine_free) begin
                r_bit_cnt <= 3'd0;
                r_gap_cnt <= 4'd0;
                if (r_full) begin
                    r_shift    <= {HEADER, r_hold};
                    r_data_out <= HEADER[7];
                    r_state    <= S_HEAD;
                    r_busy     <= 1'b1;
                end else begin
                    r_data_out <= 1'b0;
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_HEAD: begin
                        // Rotate rather than shift: bit 15 is already on data_out.
                        r_shift    <= {r_shift[14:0], r_shift[15]};
                        r_data_out <= r_shift[14];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_BODY;
                        end
                    end
                    S_BODY: begin
                        if (r_bit_cnt == 3'd7) begin
                            r_state    <= S_GAP;
                            r_data_out <= 1'b0;
                            r_gap_cnt  <= 4'd0;
                        end else begin
                            r_shift    <= {r_shift[14:0], r_shift[15]};
                            r_data_out <= r_shift[14];
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                        end
                    end
                    S_GAP: begin
                        r_data_out <= 1'b0;
                        r_gap_cnt  <= r_gap_cnt + 4'd1;
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_data_out <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign full     = r_full;
    assign busy     = r_busy;
    assign drop     = r_drop;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_xmit.sv
// Bench for xmit: two instances (GAP=0 and GAP=3) driven identically, checked
// every cycle against a frame-stream model, plus literal bit-pattern checks.
module tb_xmit;

    logic       clock;
    logic       reset;
    logic       load;
    logic [7:0] data_in;

    logic full0, busy0, drop0, dout0;
    logic full1, busy1, drop1, dout1;

    int checks = 0;
    int failures = 0;

    xmit #(.HEADER(8'hA5), .GAP(0)) dut0 (
        .clock(clock), .reset(reset), .load(load), .data_in(data_in),
        .full(full0), .busy(busy0), .drop(drop0), .data_out(dout0)
    );

    xmit #(.HEADER(8'hA5), .GAP(3)) dut1 (
        .clock(clock), .reset(reset), .load(load), .data_in(data_in),
        .full(full1), .busy(busy1), .drop(drop1), .data_out(dout1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: each instance holds at most one queued byte; a frame is the 16-bit
    // word {A5,byte} followed by GAP zeros, walked by a position index.
    int          m_gap    [2] = '{0, 3};
    logic        m_full   [2];
    logic [7:0]  m_hold   [2];
    logic [15:0] m_frame  [2];
    int          m_pos    [2];
    logic        m_active [2];
    logic        m_drop   [2];
    logic        m_out    [2];
    logic        seen_reset = 1'b0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 0; m_hold[k] = 0; m_frame[k] = 0; m_pos[k] = 0;
            m_active[k] = 0; m_drop[k] = 0; m_out[k] = 0;
        end
    end

    always @(posedge clock) begin
        if (reset) seen_reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_full[k] = 0; m_active[k] = 0; m_drop[k] = 0; m_out[k] = 0; m_pos[k] = 0;
            end else begin
                logic       fb;
                logic [7:0] hb;
                fb = m_full[k];
                hb = m_hold[k];
                if (m_active[k] && (m_pos[k] + 1 < 16 + m_gap[k])) begin
                    m_pos[k] = m_pos[k] + 1;
                end else if (fb) begin
                    m_frame[k]  = {8'hA5, hb};
                    m_pos[k]    = 0;
                    m_active[k] = 1;
                    m_full[k]   = 0;
                end else begin
                    m_active[k] = 0;
                end
                if (load && !fb) begin
                    m_full[k] = 1;
                    m_hold[k] = data_in;
                end
                m_drop[k] = load && fb;
                m_out[k]  = (m_active[k] && m_pos[k] < 16) ? m_frame[k][15 - m_pos[k]] : 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (seen_reset) begin
            check("g0_data_out", 64'(dout0), 64'(m_out[0]));
            check("g0_full",     64'(full0), 64'(m_full[0]));
            check("g0_busy",     64'(busy0), 64'(m_active[0]));
            check("g0_drop",     64'(drop0), 64'(m_drop[0]));
            check("g3_data_out", 64'(dout1), 64'(m_out[1]));
            check("g3_full",     64'(full1), 64'(m_full[1]));
            check("g3_busy",     64'(busy1), 64'(m_active[1]));
            check("g3_drop",     64'(drop1), 64'(m_drop[1]));
        end
    end

    task automatic cyc(input logic l, input logic [7:0] d, input logic r);
        @(negedge clock);
        load    = l;
        data_in = d;
        reset   = r;
    endtask

    logic [31:0] cap0;
    logic [34:0] cap1;

    initial begin
        reset = 1'b1; load = 1'b0; data_in = 8'h00;
        repeat (3) cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        check("reset_data_out", 64'(dout0), 64'd0);
        check("reset_full",     64'(full0), 64'd0);
        check("reset_busy",     64'(busy0), 64'd0);
        repeat (5) cyc(0, 8'h00, 0);

        // Single byte 3C
        cyc(1, 8'h3C, 0);
        cyc(0, 8'h00, 0);
        cap0 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(0, 8'h00, 0);
            cap0 = {cap0[30:0], dout0};
        end
        check("single_bits", 64'(cap0[15:0]), 64'h0000_0000_0000_A53C);
        check("single_busy_last", 64'(busy0), 64'd1);
        cyc(0, 8'h00, 0);
        check("single_after_out",  64'(dout0), 64'd0);
        check("single_after_busy", 64'(busy0), 64'd0);
        repeat (10) cyc(0, 8'h00, 0);

        // Queued bytes 81 then 7E
        cyc(1, 8'h81, 0);
        cyc(0, 8'h00, 0);
        cap0 = 0; cap1 = 0;
        for (int i = 0; i < 35; i++) begin
            cyc((i == 1) ? 1'b1 : 1'b0, 8'h7E, 0);
            if (i < 32) cap0 = {cap0[30:0], dout0};
            cap1 = {cap1[33:0], dout1};
            if (i == 2)  check("queued_full_held", 64'(full0), 64'd1);
            if (i == 16) check("queued_full_clear", 64'(full0), 64'd0);
        end
        check("queued_g0_stream", 64'(cap0), 64'hA581A57E);
        check("queued_g3_stream", 64'(cap1), 64'({16'hA581, 3'b000, 16'hA57E}));
        repeat (30) cyc(0, 8'h00, 0);

        // Overflow: FF offered while full
        cyc(1, 8'h11, 0);
        cyc(0, 8'h00, 0);
        cyc(1, 8'h22, 0);
        cyc(1, 8'hFF, 0);
        cyc(0, 8'h00, 0);
        check("overflow_drop", 64'(drop0), 64'd1);
        check("overflow_full", 64'(full0), 64'd1);
        cyc(0, 8'h00, 0);
        check("overflow_drop_once", 64'(drop0), 64'd0);
        repeat (45) cyc(0, 8'h00, 0);

        // Reset mid-frame with a byte queued
        cyc(1, 8'h5A, 0);
        cyc(0, 8'h00, 0);
        cyc(1, 8'hC3, 0);
        repeat (3) cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0);
        check("abort_data_out", 64'(dout0), 64'd0);
        check("abort_full",     64'(full0), 64'd0);
        check("abort_busy",     64'(busy0), 64'd0);
        repeat (20) cyc(0, 8'h00, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0, 8'($urandom),
                ($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0);
        end
        repeat (60) cyc(0, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
